// File: rtl/gray_conv_pkg.sv
// Shared definitions for the dual-channel Gray/binary converter arbiter.
// Holds the default word width, direction encodings, channel ids and the
// output-slot state type used by gray_conv_arbiter and gray_xlate.
package gray_conv_pkg;

  localparam int WIDTH_DEF = 4;

  // Direction bit carried with each request
  localparam logic MODE_BIN2GRAY = 1'b0;
  localparam logic MODE_GRAY2BIN = 1'b1;

  // Channel ids as reported on resp_id
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Single-entry output slot
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/gray_xlate.sv
// Combinational WIDTH-bit binary<->Gray converter, mode selects direction.
// Latency: none (pure combinational).
// Backpressure: n/a.
// Ports: mode (0 = bin->gray, 1 = gray->bin), din (input word), dout (result).
module gray_xlate
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] g2b;

  always_comb begin
    b2g = din ^ (din >> 1);
    // Each binary bit is the XOR of all Gray bits from itself up to the MSB;
    // expressing it as a reduction avoids a self-referencing ripple vector.
    g2b = '0;
    for (int k = 0; k < WIDTH; k++) begin
      g2b[k] = ^(din >> k);
    end
    dout = (mode == MODE_GRAY2BIN) ? g2b : b2g;
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray/binary converter between two channels.
// Latency: 1 cycle from accept to resp_valid/resp_data; 1 word/cycle sustained.
// Backpressure: req_ready drops to 00 while the result slot is full and resp_ready=0.
// Ports: clk, reset (async active-high); req_valid/req_ready/req_data0/req_data1/
//   req_mode per-channel request handshake; resp_valid/resp_ready/resp_data/resp_id
//   result handshake. Optional busy_cnt0/busy_cnt1 transfer counters are present
//   only when GRAY_ARB_COUNT_EN is defined.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [1:0]       req_mode,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id
`ifdef GRAY_ARB_COUNT_EN
  ,
  output logic [7:0]       busy_cnt0,
  output logic [7:0]       busy_cnt1
`endif
);

  slot_state_t      state;
  logic             last_id;
  logic             can_load;
  logic [1:0]       grant;
  logic             xfer;
  logic             sel;
  logic [WIDTH-1:0] mux_data;
  logic             mux_mode;
  logic [WIDTH-1:0] conv_data;

  always_comb begin
    // Slot accepts a new word when empty, or when the current one is popped now.
    can_load = (state == SLOT_EMPTY) || resp_ready;
    // On a tie the channel not served last wins; otherwise the lone requester.
    if (req_valid == 2'b11) begin
      grant = (last_id == CH0) ? 2'b10 : 2'b01;
    end else begin
      grant = req_valid;
    end
    req_ready = can_load ? grant : 2'b00;
    xfer      = |req_ready;
    sel       = req_ready[1];
    mux_data  = sel ? req_data1 : req_data0;
    mux_mode  = req_mode[sel];
  end

  gray_xlate #(
    .WIDTH (WIDTH)
  ) u_xlate (
    .mode (mux_mode),
    .din  (mux_data),
    .dout (conv_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SLOT_EMPTY;
      resp_data <= '0;
      resp_id   <= CH0;
      last_id   <= CH1;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (xfer) begin
            state     <= SLOT_FULL;
            resp_data <= conv_data;
            resp_id   <= sel;
            last_id   <= sel;
          end
        end
        SLOT_FULL: begin
          // A push while full only happens alongside a pop, so the new word
          // simply replaces the old one and the slot stays full.
          if (xfer) begin
            resp_data <= conv_data;
            resp_id   <= sel;
            last_id   <= sel;
          end else if (resp_ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

  assign resp_valid = (state == SLOT_FULL);

`ifdef GRAY_ARB_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt0 <= 8'd0;
      busy_cnt1 <= 8'd0;
    end else if (xfer) begin
      if (sel == CH0) begin
        busy_cnt0 <= busy_cnt0 + 8'd1;
      end else begin
        busy_cnt1 <= busy_cnt1 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one 4-bit binary/Gray code converter between two requesting channels. Each channel presents a code word plus a direction bit over a valid/ready handshake. The block grants one channel per cycle, runs the word through the shared converter, and returns a registered result tagged with the source channel. It sits between the dual-channel switch/button front end and the display/LED back end of the dual converter design.

## Interface
- WIDTH, 4, code word width; the converter chain spans WIDTH bits.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-channel request valid; bit i = channel i.
- req_ready  output  2  per-channel accept; at most one bit set per cycle.
- req_data0  input  WIDTH  channel 0 code word.
- req_data1  input  WIDTH  channel 1 code word.
- req_mode  input  2  per-channel direction: 0 = binary→Gray, 1 = Gray→binary.
- resp_valid  output  1  result held in the output register.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  WIDTH  converted word.
- resp_id  output  1  channel that produced resp_data.
- busy_cnt0, busy_cnt1  output  8 each  completed-transfer counters (only with GRAY_ARB_COUNT_EN).

## Operation
- Conversion rules: binary→Gray out[MSB]=in[MSB], out[k]=in[k]^in[k+1]. Gray→binary out[MSB]=in[MSB], out[k]=in[k]^out[k+1], a ripple from MSB down.
- Output slot states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
- Slot can load when EMPTY, or when FULL and resp_ready=1 in the same cycle.
- Grant when the slot can load:
  - Only one channel valid: grant that channel.
  - Both valid: grant the channel not recorded in last_id.
  - req_ready[i] = grant[i] AND slot can load. This is combinational from req_valid, resp_ready and state.
- Transfer on req_valid[i] & req_ready[i]:
  - Register the converted word into resp_data and i into resp_id.
  - Set resp_valid=1 and last_id=i.
- FULL with resp_ready=1 and no transfer: go EMPTY; resp_data and resp_id keep their values.
- FULL with resp_ready=0: hold resp_data, resp_id and resp_valid; req_ready=00.
- Requester inputs are sampled only on a transfer. Changing them while unaccepted is legal.
- Reset (any time, including mid-transfer):
  - resp_valid=0, resp_data=0, resp_id=0, last_id=1, so channel 0 wins the first tie.
  - Counters reset to 0. The pending result is discarded.

## Timing
- Latency: accept in cycle N → resp_valid and data visible after edge N+1 (1 cycle).
- Throughput: 1 word/cycle while resp_ready stays high. Under sustained contention, grants alternate 0,1,0,1.
- Simultaneous pop and push in FULL: the new result replaces the old; resp_valid stays 1.
- No combinational path from req_data* to resp_data. A path from resp_ready to req_ready is permitted.

## Configuration
- GRAY_ARB_COUNT_EN defined:
  - busy_cnt0 and busy_cnt1 increment by 1 on each transfer from their channel, wrapping 255→0.
- Not defined:
  - The ports are absent and no counter logic is built.

## Structure
- Shared package gray_conv_pkg holds:
  - WIDTH default.
  - MODE_BIN2GRAY=0 and MODE_GRAY2BIN=1.
  - CH0/CH1 id constants.
- One sub-module, gray_xlate: a combinational WIDTH-bit converter with a mode input and data in/out, instantiated once on the granted channel's muxed data.

## Test plan
- Single request: ch0 valid, data 4'b0110, mode 0, resp_ready=1 → next cycle resp_valid=1, resp_data=4'b0101, resp_id=0.
- Gray→binary: ch1 data 4'b0101, mode 1 → resp_data=4'b0110, resp_id=1.
- Contention after reset: both valid every cycle with resp_ready=1 → grant order 0,1,0,1; req_ready never 11.
- Backpressure: slot FULL, resp_ready=0 for 3 cycles → req_ready=00 and resp_data stable; on release, the pop and the next push occur in the same cycle.
- Reset mid-hold: assert reset while FULL → resp_valid=0 immediately (async); after release, a tie grants channel 0.
- With GRAY_ARB_COUNT_EN: 257 ch0 transfers → busy_cnt0=1, busy_cnt1=0.
